// File: rtl/vram32_writer.sv
// Command FIFO plus commit FSM driving the VRAM32 write port one word per cycle.
// Optional vblank gating of pops and writes: define VRAM32W_VBLANK_GATE_EN.
module vram32_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32
) (
    input  logic                            vga_clk,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_fill,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [DATA_W-1:0]               req_data,
    input  logic [ADDR_W-1:0]               req_count,
    input  logic                            vblank,
    output logic                            vram32_we,
    output logic [ADDR_W-1:0]               vram32_waddr,
    output logic [DATA_W-1:0]               vram32_d,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t state;

    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data  [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_count [FIFO_DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  level;

    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic [ADDR_W-1:0] remaining;

    logic gate;
    logic push;
    logic pop;
    logic fifo_empty;

`ifdef VRAM32W_VBLANK_GATE_EN
    assign gate = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign gate          = 1'b1;
`endif

    assign fifo_empty = (level == '0);
    assign req_ready  = (level != LVL_W'(FIFO_DEPTH));
    assign push       = req_valid && req_ready;
    // Pops only happen from IDLE, so a queued command never overtakes the active fill.
    assign pop        = (state == IDLE) && !fifo_empty && gate;
    assign busy       = !fifo_empty || (state != IDLE);
    assign fifo_level = level;

    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= req_addr;
            fifo_data[wr_ptr]  <= req_data;
            fifo_count[wr_ptr] <= req_fill ? req_count : ADDR_W'(1);
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state        <= IDLE;
            cur_addr     <= '0;
            cur_data     <= '0;
            remaining    <= '0;
            vram32_we    <= 1'b0;
            vram32_waddr <= '0;
            vram32_d     <= '0;
        end else begin
            vram32_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_addr  <= fifo_addr[rd_ptr];
                        cur_data  <= fifo_data[rd_ptr];
                        remaining <= fifo_count[rd_ptr];
                        // A zero-length fill is consumed here and never reaches EXEC.
                        if (fifo_count[rd_ptr] != '0) begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (gate) begin
                        vram32_we    <= 1'b1;
                        vram32_waddr <= cur_addr;
                        vram32_d     <= cur_data;
                        cur_addr     <= cur_addr + ADDR_W'(1);
                        remaining    <= remaining - ADDR_W'(1);
                        if (remaining == ADDR_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram32_writer.sv
// Self-checking bench for vram32_writer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram32_writer;

    localparam int DEPTH = 8;
    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          vga_clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_fill;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic [AW-1:0] req_count;
    logic          vblank;
    logic          vram32_we;
    logic [AW-1:0] vram32_waddr;
    logic [DW-1:0] vram32_d;
    logic          busy;
    logic [LW-1:0] fifo_level;

    vram32_writer #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_fill    (req_fill),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_count   (req_count),
        .vblank      (vblank),
        .vram32_we   (vram32_we),
        .vram32_waddr(vram32_waddr),
        .vram32_d    (vram32_d),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic started = 1'b0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: commands queue, one active fill, last written word.
    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] c;
    } cmd_t;

    cmd_t          mq[$];
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    int            m_left  = 0;
    logic          m_we    = 1'b0;
    logic [AW-1:0] m_waddr = '0;
    logic [DW-1:0] m_d     = '0;
    logic          m_gate;
    logic          m_acc;
    cmd_t          m_c;

    always @(posedge vga_clk) begin
        cyc++;
`ifdef VRAM32W_VBLANK_GATE_EN
        m_gate = vblank;
`else
        m_gate = 1'b1;
`endif
        m_acc = req_valid && (mq.size() < DEPTH);
        if (reset) begin
            mq.delete();
            m_left  = 0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_d     = '0;
        end else begin
            m_we = 1'b0;
            if (m_left > 0) begin
                if (m_gate) begin
                    m_we    = 1'b1;
                    m_waddr = m_addr;
                    m_d     = m_data;
                    m_addr  = m_addr + 1'b1;
                    m_left  = m_left - 1;
                end
            end else if (mq.size() > 0 && m_gate) begin
                m_c = mq.pop_front();
                if (m_c.c != 0) begin
                    m_addr = m_c.a;
                    m_data = m_c.d;
                    m_left = int'(m_c.c);
                end
            end
            if (m_acc) begin
                mq.push_back('{a: req_addr, d: req_data, c: (req_fill ? req_count : AW'(1))});
            end
        end
    end

    // Observed write log for directed literal checks.
    typedef struct {
        int            e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t wlog[$];

    always @(negedge vga_clk) begin
        if (started) begin
            if (vram32_we === 1'b1) wlog.push_back('{cyc, vram32_waddr, vram32_d});
            check("we", vram32_we, m_we);
            check("waddr", vram32_waddr, m_waddr);
            check("d", vram32_d, m_d);
            check("fifo_level", fifo_level, mq.size());
            check("req_ready", req_ready, mq.size() < DEPTH);
            check("busy", busy, (mq.size() != 0) || (m_left != 0));
        end
    end

    task automatic send(input logic fill, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [AW-1:0] c, output int acc);
        int n = 0;
        req_valid = 1'b1;
        req_fill  = fill;
        req_addr  = a;
        req_data  = d;
        req_count = c;
        while (req_ready !== 1'b1 && n < 500) begin
            @(negedge vga_clk);
            n++;
        end
        if (n >= 500) begin
            check("send_timeout", 1, 0);
        end
        @(negedge vga_clk);
        acc       = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((mq.size() != 0 || m_left != 0) && n < 3000) begin
            @(negedge vga_clk);
            n++;
        end
        if (n >= 3000) check("idle_timeout", 1, 0);
        repeat (3) @(negedge vga_clk);
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int acc, acc2, tmp, n, lo_start, lo_end, rise;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_fill  = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_count = '0;
        vblank    = 1'b1;
        @(negedge vga_clk);
        started = 1'b1;
        check("rst_we", vram32_we, 0);
        check("rst_waddr", vram32_waddr, 0);
        check("rst_d", vram32_d, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);

        // Single write latency
        wlog.delete();
        send(1'b0, 14'h0400, 32'hDEADBEEF, 14'd9, acc);
        wait_idle();
        check("t1_nwr", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            check("t1_edge", wlog[0].e, acc + 2);
            check("t1_addr", wlog[0].a, 14'h0400);
            check("t1_data", wlog[0].d, 32'hDEADBEEF);
        end
        check("t1_busy", busy, 0);

        // Fill across the address wrap
        wlog.delete();
        send(1'b1, 14'h3FFE, 32'h000000E3, 14'd4, acc);
        wait_idle();
        check("t2_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            check("t2_edge", wlog[i].e, acc + 2 + i);
            check("t2_addr", wlog[i].a, AW'(14'h3FFE + i));
            check("t2_data", wlog[i].d, 32'h000000E3);
        end

        // Backpressure: a long fill keeps the FSM busy while eight singles queue up
        wlog.delete();
        send(1'b1, 14'h0800, 32'h11, 14'd20, acc);
        for (int k = 0; k < 8; k++) send(1'b0, AW'(14'h0900 + k), DW'(32'hA0 + k), 14'd0, tmp);
        check("t3_level_full", fifo_level, 8);
        check("t3_ready_low", req_ready, 0);
        req_valid = 1'b1;
        req_fill  = 1'b0;
        req_addr  = 14'h0999;
        req_data  = 32'h999;
        repeat (3) @(negedge vga_clk);
        check("t3_level_after_offer", fifo_level, 8);
        req_valid = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(negedge vga_clk);
            n++;
        end
        rise = cyc;
        check("t3_ready_rise_level", fifo_level, 7);
        wait_idle();
        check("t3_nwr", wlog.size(), 28);
        if (wlog.size() == 28) begin
            check("t3_first_single_edge", wlog[20].e, rise + 1);
            for (int k = 0; k < 8; k++) begin
                check("t3_order_addr", wlog[20 + k].a, AW'(14'h0900 + k));
                check("t3_order_data", wlog[20 + k].d, DW'(32'hA0 + k));
            end
        end

        // vblank drop in the middle of a fill
        wlog.delete();
        send(1'b1, 14'h1230, 32'hCAFE0006, 14'd6, acc);
        n = 0;
        while (wlog.size() < 2 && n < 50) begin
            @(negedge vga_clk);
            n++;
        end
        vblank   = 1'b0;
        lo_start = cyc + 1;
        repeat (10) @(negedge vga_clk);
        vblank = 1'b1;
        lo_end = cyc;
        wait_idle();
        check("t4_nwr", wlog.size(), 6);
        for (int i = 0; i < wlog.size(); i++) begin
            check("t4_addr", wlog[i].a, AW'(14'h1230 + i));
`ifdef VRAM32W_VBLANK_GATE_EN
            check("t4_no_we_in_gap", (wlog[i].e >= lo_start && wlog[i].e <= lo_end), 0);
`endif
        end
        if (wlog.size() == 6) begin
`ifdef VRAM32W_VBLANK_GATE_EN
            check("t4_resume_edge", wlog[2].e, lo_end + 1);
`else
            check("t4_resume_edge", wlog[2].e, acc + 4);
`endif
        end

        // Zero-length fill then a single write
        wlog.delete();
        send(1'b1, 14'h0200, 32'h77, 14'd0, acc);
        send(1'b0, 14'h0010, 32'h55, 14'd0, acc2);
        wait_idle();
        check("t5_nwr", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            check("t5_edge", wlog[0].e, acc + 3);
            check("t5_addr", wlog[0].a, 14'h0010);
        end

        // Reset during the third word of a fill with two entries queued
        wlog.delete();
        send(1'b1, 14'h0100, 32'h88, 14'd8, acc);
        send(1'b0, 14'h0300, 32'h1, 14'd0, tmp);
        send(1'b0, 14'h0301, 32'h2, 14'd0, tmp);
        @(negedge vga_clk);
        reset = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        check("t6_we_at_reset", vram32_we, 0);
        repeat (20) @(negedge vga_clk);
        check("t6_nwr", wlog.size(), 2);
        check("t6_level", fifo_level, 0);
        check("t6_busy", busy, 0);
        check("t6_waddr", vram32_waddr, 0);

        // Randomized traffic
        for (int i = 0; i < 1200; i++) begin
            @(negedge vga_clk);
            if ($urandom_range(0, 9) == 0) vblank = ~vblank;
            req_valid = ($urandom_range(0, 2) == 0);
            req_fill  = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 3) == 0) ? AW'(14'h3FFC + $urandom_range(0, 3)) : AW'($urandom);
            req_data  = DW'($urandom);
            req_count = AW'($urandom_range(0, 6));
            reset     = ($urandom_range(0, 299) == 0);
        end
        @(negedge vga_clk);
        req_valid = 1'b0;
        reset     = 1'b0;
        vblank    = 1'b1;
        wait_idle();
        check("end_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram32_writer.md
# vram32_writer

Write-side counterpart to the GPU's VRAM32 readers. It accepts CPU write commands (single word or constant fill) into a small FIFO and commits them to the VRAM32 write port at one word per cycle. Commits are optionally restricted to vertical blanking, so the sprite and background renderers never fetch half-updated patterns or palettes mid-frame. It sits between the CPU bus bridge and the VRAM32 write port; the renderers keep the read port.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8. Command FIFO entries; power of two, at least 2.
- `ADDR_W`, default 14. VRAM32 word address width.
- `DATA_W`, default 32. VRAM32 word width.

Ports (one clock; reset is synchronous and active-high):
- `vga_clk`  in  1  Sole clock. All logic is on posedge.
- `reset`  in  1  Synchronous, active-high.
- `req_valid`  in  1  Command offered.
- `req_ready`  out  1  FIFO not full. A command is accepted on a posedge where `req_valid && req_ready`.
- `req_fill`  in  1  0: single write; 1: fill.
- `req_addr`  in  ADDR_W  Start word address.
- `req_data`  in  DATA_W  Word to write (repeated for fill).
- `req_count`  in  ADDR_W  Fill length in words. Ignored when `req_fill`=0, which is treated as count 1.
- `vblank`  in  1  High during vertical blanking.
- `vram32_we`  out  1  Registered write strobe.
- `vram32_waddr`  out  ADDR_W  Registered write address.
- `vram32_d`  out  DATA_W  Registered write data.
- `busy`  out  1  FIFO non-empty, or FSM not IDLE.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  Current entry count.

## Operation

- FIFO entry: {addr, data, count}. A single write is stored with count=1.
- `gate` = `vblank` when VRAM32W_VBLANK_GATE_EN is defined; otherwise constant 1.
- FSM states are IDLE and EXEC.
- **IDLE:**
  - If FIFO is non-empty and `gate`=1: pop the entry into cur_addr, cur_data, remaining.
  - If the popped count is 0: discard it and stay in IDLE.
  - Otherwise: go to EXEC.
  - If FIFO is empty or `gate`=0: stay in IDLE.
- **EXEC, `gate`=1:**
  - Register we=1, waddr=cur_addr, d=cur_data.
  - cur_addr increments modulo 2^ADDR_W, so 0x3FFF wraps to 0x0000.
  - remaining decrements; when it reaches 0, go to IDLE.
- **EXEC, `gate`=0:**
  - Register we=0 and hold state. The fill pauses and resumes at the same address when the gate reopens. No words are dropped.
- `vram32_we` is 0 in every cycle not described above. `vram32_waddr` and `vram32_d` hold their last values when we=0.
- Push and pop in the same cycle: `fifo_level` is unchanged. A push into a full FIFO is impossible because `req_ready` is low. There is no bypass path: an accepted command always passes through the FIFO.
- Commands commit strictly in acceptance order, each one fully before the next.

## Timing

- Reset (synchronous, takes effect at the posedge where `reset`=1): FIFO emptied, state IDLE, `vram32_we`=0, `vram32_waddr`=0, `vram32_d`=0, `busy`=0, `fifo_level`=0, `req_ready`=1.
- Reset mid-fill: the remaining words are abandoned and queued entries are lost. `vram32_we` is 0 from the reset edge onward.
- `req_ready` is combinational from `fifo_level` (`fifo_level` != FIFO_DEPTH). It does not depend on `req_valid`.
- Latency with `gate` open and the FSM idle:
  - Accept at edge N.
  - Pop at edge N+1.
  - First `vram32_we`=1 is registered at edge N+2.
  - A fill of length K keeps we high for K consecutive cycles, from edge N+2 through edge N+K+1.
- Throughput: one word per cycle within a fill. There is a 1-cycle bubble (IDLE pop) between consecutive commands.
- Gate sampling: `gate` is sampled at the same edge that would issue the write. A word is issued only if `gate`=1 at that edge.

## Configuration

- `VRAM32W_VBLANK_GATE_EN` defined:
  - Pops and writes occur only while `vblank`=1.
  - Commands accepted during active video wait in the FIFO.
  - An in-progress fill pauses at the end of vblank and resumes in the next vblank.
- `VRAM32W_VBLANK_GATE_EN` undefined:
  - `vblank` is ignored (gate = 1) and commits are immediate.
  - Used for boot-time loading with the display off.

## Test plan

1. Ungated: single write addr=0x0400, data=0xDEADBEEF accepted at edge N. Required: we=1 at edge N+2 with waddr=0x0400, d=0xDEADBEEF, for exactly 1 cycle; `busy` returns to 0 afterwards.
2. Fill addr=0x3FFE, count=4, data=0x000000E3. Required: 4 consecutive we cycles with waddr 0x3FFE, 0x3FFF, 0x0000, 0x0001, all carrying d=0x000000E3.
3. Backpressure: hold `vblank`=0 (gated build) and push 8 singles. Required: `fifo_level`=8, `req_ready`=0, and a 9th offer is not accepted. Then raise `vblank`: the 8 writes appear in order, and `req_ready`=1 the cycle after the first pop.
4. Gated fill count=6: drop `vblank` after the 2nd write and raise it 10 cycles later. Required: no we while `vblank`=0, then the 3rd through 6th writes continue at the next addresses with no word lost or duplicated.
5. Fill with count=0 followed by a single write to 0x0010. Required: no write for the fill; the single write appears with exactly 1 extra cycle of delay (one discard pop).
6. Reset asserted during the 3rd word of a count=8 fill, with 2 entries queued. Required: we=0 from the reset edge onward, `fifo_level`=0, `busy`=0, `vram32_waddr`=0, and no further writes.
